// File: rtl/icache_if.sv
// Bundle of the fetch-side lookup signals and the memory-side word refill handshake.
// master is the cache side, slave is the fetch unit plus memory controller side.
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] if_addr_in;
    logic              if_instr_en_out;
    logic [31:0]       if_instr_out;
    logic              mem_req_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_done_in;
    logic [31:0]       mem_data_in;

    modport master (
        input  if_addr_in,
        input  mem_done_in,
        input  mem_data_in,
        output if_instr_en_out,
        output if_instr_out,
        output mem_req_out,
        output mem_addr_out
    );

    modport slave (
        output if_addr_in,
        output mem_done_in,
        output mem_data_in,
        input  if_instr_en_out,
        input  if_instr_out,
        input  mem_req_out,
        input  mem_addr_out
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, 4-word line refill
// fetched one word at a time over a request/done handshake.
//
//   state  | meaning
//   IDLE   | lookups answered; a miss with rdy_in high launches a refill
//   REFILL | collecting 4 words of the latched line; hits suppressed
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic     clk,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.master bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 4;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][4];

    logic [ADDR_W-5:0] miss_line_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_inc;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       linebuf_q [3];

    logic [1:0]            off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  hit;
    logic                  fill_start;
    logic                  fill_word;
    logic                  fill_last;
    logic                  unused_addr_lsbs;

    assign off      = bus.if_addr_in[3:2];
    assign idx      = bus.if_addr_in[INDEX_BITS+3:4];
    assign tag      = bus.if_addr_in[ADDR_W-1:INDEX_BITS+4];
    assign miss_idx = miss_line_q[INDEX_BITS-1:0];
    assign miss_tag = miss_line_q[ADDR_W-5:INDEX_BITS];
    assign cnt_inc  = cnt_q + 2'd1;

    // Instruction fetches are word aligned; the byte offset carries no information here.
    assign unused_addr_lsbs = ^bus.if_addr_in[1:0];

    assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);

    assign bus.if_instr_en_out = hit;
    assign bus.if_instr_out    = hit ? data_q[idx][off] : 32'd0;
    assign bus.mem_req_out     = mem_req_q;
    assign bus.mem_addr_out    = mem_addr_q;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_start = 1'b0;
        fill_word  = 1'b0;
        fill_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_in && !hit) begin
                    fill_start = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (rdy_in && bus.mem_done_in) begin
                    fill_word = 1'b1;
                    if (cnt_q == 2'd3) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            valid_q     <= '0;
            cnt_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            miss_line_q <= '0;
        end else if (fill_start) begin
            miss_line_q <= bus.if_addr_in[ADDR_W-1:4];
            cnt_q       <= 2'd0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {bus.if_addr_in[ADDR_W-1:4], 4'b0000};
        end else if (fill_word) begin
            if (fill_last) begin
                mem_req_q         <= 1'b0;
                valid_q[miss_idx] <= 1'b1;
            end else begin
                cnt_q      <= cnt_inc;
                mem_addr_q <= {miss_line_q, cnt_inc, 2'b00};
            end
        end
    end

    // Storage arrays carry no reset: only the valid bits define what the cache holds.
    always_ff @(posedge clk) begin
        if (fill_word && !fill_last) begin
            linebuf_q[cnt_q] <= bus.mem_data_in;
        end
        if (fill_last) begin
            tag_q[miss_idx]     <= miss_tag;
            data_q[miss_idx][0] <= linebuf_q[0];
            data_q[miss_idx][1] <= linebuf_q[1];
            data_q[miss_idx][2] <= linebuf_q[2];
            data_q[miss_idx][3] <= bus.mem_data_in;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: memory responder with programmable latency, table vectors,
// directed corner sequences, and random lookups against a line-presence model.
module tb_icache;
    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    always #5 clk = ~clk;

    icache_if #(.ADDR_W(32)) bus ();

    icache #(.INDEX_BITS(6), .ADDR_W(32)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    logic        r_done = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] r_data = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] addr   = 32'd0;

    assign bus.if_addr_in  = addr;
    assign bus.mem_done_in = r_done | m_done;
    assign bus.mem_data_in = m_done ? m_data : r_data;

    int          checks = 0;
    int          errors = 0;
    int          lat = 2;
    bit          auto_en = 1'b1;
    logic [31:0] req_log [$];

    typedef struct {
        logic [31:0] a;
        logic        en;
        logic [31:0] instr;
    } vec_t;

    vec_t vt [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0:   return 32'h00000013;
            32'h4:   return 32'h00100093;
            32'h8:   return 32'h00200113;
            32'hC:   return 32'h00300193;
            default: return (w * 32'h9E3779B1) ^ 32'hA5A50F0F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory controller: answers each visible request lat cycles later, paused by rdy_in.
    initial begin
        int wc;
        wc = 0;
        forever begin
            @(posedge clk);
            #1;
            r_done = 1'b0;
            if (!auto_en || !rst_in || !bus.mem_req_out) begin
                wc = 0;
            end else if (rdy_in) begin
                if (wc >= lat) begin
                    r_done = 1'b1;
                    r_data = mem_word(bus.mem_addr_out);
                    req_log.push_back(bus.mem_addr_out);
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
    end

    task automatic wait_hit(output int n);
        n = 0;
        while (!bus.if_instr_en_out && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bit("hit_timeout", bus.if_instr_en_out, 1'b1);
    endtask

    task automatic wait_log(input int k);
        int n;
        n = 0;
        while (req_log.size() < k && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_bit("log_timeout", req_log.size() >= k, 1'b1);
    endtask

    task automatic do_miss(input logic [31:0] a, input int l, input string nm);
        int          n;
        logic [31:0] base;
        base = {a[31:4], 4'b0000};
        lat  = l;
        @(negedge clk);
        rdy_in = 1'b1;
        req_log.delete();
        addr = a;
        #1;
        check_bit({nm, "_miss_en"}, bus.if_instr_en_out, 1'b0);
        check({nm, "_miss_instr"}, bus.if_instr_out, 32'd0);
        wait_hit(n);
        check({nm, "_penalty"}, n, 1 + 4 * (l + 1));
        check({nm, "_nreq"}, req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check({nm, "_req_addr"}, req_log[i], base + 32'(4 * i));
        check({nm, "_instr"}, bus.if_instr_out, mem_word(a));
        check_bit({nm, "_req_idle"}, bus.mem_req_out, 1'b0);
    endtask

    initial begin
        int          n;
        logic [31:0] exp8 [8];
        logic        mvalid [64];
        logic [1:0]  mtag   [64];

        vt[0] = '{32'h0,   1'b1, 32'h00000013};
        vt[1] = '{32'h4,   1'b1, 32'h00100093};
        vt[2] = '{32'h8,   1'b1, 32'h00200113};
        vt[3] = '{32'hC,   1'b1, 32'h00300193};
        vt[4] = '{32'h7,   1'b1, 32'h00100093};
        vt[5] = '{32'h10,  1'b0, 32'h0};
        vt[6] = '{32'h400, 1'b0, 32'h0};
        vt[7] = '{32'h40C, 1'b0, 32'h0};

        // Reset state, then one frozen edge with a pending miss.
        repeat (2) @(negedge clk);
        #1;
        check_bit("rst_en", bus.if_instr_en_out, 1'b0);
        check("rst_instr", bus.if_instr_out, 32'd0);
        check_bit("rst_req", bus.mem_req_out, 1'b0);
        check("rst_addr", bus.mem_addr_out, 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        #1;
        check_bit("frozen_req", bus.mem_req_out, 1'b0);

        // First fill of line 0 with 2-cycle memory latency.
        do_miss(32'h0, 2, "fill0");
        @(negedge clk);
        addr = 32'h8;
        #1;
        check_bit("hit8_en", bus.if_instr_en_out, 1'b1);
        check("hit8_instr", bus.if_instr_out, 32'h00200113);
        @(negedge clk);
        #1;
        check_bit("hit8_noreq", bus.mem_req_out, 1'b0);

        // Table vectors with rdy_in low: pure combinational lookup, nothing may launch.
        rdy_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr = vt[i].a;
            #1;
            check_bit("vec_en", bus.if_instr_en_out, vt[i].en);
            check("vec_instr", bus.if_instr_out, vt[i].instr);
            check_bit("vec_noreq", bus.mem_req_out, 1'b0);
        end

        // Same-index conflict evicts and reloads.
        do_miss(32'h400, 2, "conf");
        do_miss(32'h0, 1, "conf_back");

        // Fetch redirect mid-refill.
        lat = 2;
        @(negedge clk);
        req_log.delete();
        addr = 32'h20;
        wait_log(2);
        @(negedge clk);
        addr = 32'h8;
        #1;
        check_bit("refill_blocks_hit", bus.if_instr_en_out, 1'b0);
        @(negedge clk);
        addr = 32'h100;
        #1;
        wait_hit(n);
        exp8 = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h100, 32'h104, 32'h108, 32'h10C};
        check("redir_nreq", req_log.size(), 8);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            check("redir_req_addr", req_log[i], exp8[i]);
        check("redir_instr", bus.if_instr_out, mem_word(32'h100));
        @(negedge clk);
        addr = 32'h24;
        #1;
        check_bit("redir_hit24", bus.if_instr_en_out, 1'b1);
        check("redir_instr24", bus.if_instr_out, mem_word(32'h24));

        // rdy_in low for 5 cycles between the first and second done.
        @(negedge clk);
        req_log.delete();
        addr = 32'h30;
        wait_log(1);
        @(negedge clk);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("pause_addr", bus.mem_addr_out, 32'h34);
            check_bit("pause_req", bus.mem_req_out, 1'b1);
        end
        rdy_in = 1'b1;
        #1;
        wait_hit(n);
        check("pause_nreq", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check("pause_req_addr", req_log[i], 32'h30 + 32'(4 * i));
        check("pause_instr", bus.if_instr_out, mem_word(32'h30));

        // Async reset between the 3rd and 4th done.
        @(negedge clk);
        req_log.delete();
        addr = 32'h400;
        wait_log(3);
        @(negedge clk);
        #2;
        rst_in = 1'b0;
        #1;
        check_bit("arst_req", bus.mem_req_out, 1'b0);
        check("arst_addr", bus.mem_addr_out, 32'd0);
        check_bit("arst_en", bus.if_instr_en_out, 1'b0);
        rdy_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        check_bit("arst_partial", bus.if_instr_en_out, 1'b0);
        addr = 32'h0;
        #1;
        check_bit("arst_line0", bus.if_instr_en_out, 1'b0);
        do_miss(32'h0, 0, "arst_fill");

        // Spurious done while idle must not touch the array.
        auto_en = 1'b0;
        @(negedge clk);
        addr   = 32'h0;
        m_data = 32'hDEADBEEF;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        #1;
        check_bit("spur_req", bus.mem_req_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = 32'(4 * i);
            #1;
            check("spur_instr", bus.if_instr_out, mem_word(32'(4 * i)));
        end
        auto_en = 1'b1;

        // Random lookups against a line-presence model.
        @(negedge clk);
        rst_in = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = 2'd0;
        end
        @(negedge clk);
        rst_in = 1'b1;
        for (int it = 0; it < 250; it++) begin
            int          ri;
            int          rt;
            int          rl;
            logic [31:0] a;
            ri = $urandom_range(0, 7);
            rt = $urandom_range(0, 2);
            rl = $urandom_range(0, 3);
            a  = 32'((rt << 10) | (ri << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            if (mvalid[ri] && mtag[ri] == 2'(rt)) begin
                @(negedge clk);
                rdy_in = 1'b1;
                addr   = a;
                #1;
                check_bit("rnd_hit_en", bus.if_instr_en_out, 1'b1);
                check("rnd_hit_instr", bus.if_instr_out, mem_word(a));
                check_bit("rnd_hit_noreq", bus.mem_req_out, 1'b0);
            end else begin
                do_miss(a, rl, "rnd");
                mvalid[ri] = 1'b1;
                mtag[ri]   = 2'(rt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the instruction fetch unit and the memory controller.
- Answers the fetch unit's current pc combinationally on a hit.
- On a miss, refills one 4-word line from the memory controller with a word-at-a-time request/done handshake.
- Read-only; never writes memory.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines x 16 bytes = 1 KiB)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  ready; low freezes all state
if_addr_in  input  32  fetch address from fetch unit (held combinationally by fetch)
if_instr_en_out  output  1  hit: if_instr_out valid for if_addr_in this cycle
if_instr_out  output  32  instruction word at if_addr_in
mem_req_out  output  1  word-read request to memory controller
mem_addr_out  output  32  word address of request, bits [1:0]=0
mem_done_in  input  1  one-cycle pulse: mem_data_in holds requested word
mem_data_in  input  32  returned word

Behaviour:
- Address split:
  - [1:0] ignored.
  - [3:2] word offset.
  - [INDEX_BITS+3:4] index.
  - [31:INDEX_BITS+4] tag.
- Per-line storage: valid bit, tag, 4 x 32-bit words.
- Hit, combinational:
  - Condition: state==IDLE && valid[idx] && tag[idx]==addr tag.
  - Outputs: if_instr_en_out=1, if_instr_out=word[idx][off].
  - Otherwise if_instr_en_out=0 and if_instr_out=0.
- States:
  - IDLE:
    - Stays in IDLE on a hit.
    - On a miss with rdy_in=1, at the clock edge:
      - Latch miss_base = {addr[31:4],4'b0}.
      - cnt <= 0.
      - mem_req_out <= 1, mem_addr_out <= miss_base.
      - Go to REFILL.
  - REFILL:
    - if_instr_en_out=0 for the whole state, even if if_addr_in hits another line.
    - On mem_done_in=1:
      - linebuf[cnt] <= mem_data_in.
      - If cnt<3: cnt <= cnt+1 and mem_addr_out <= miss_base + 4*(cnt+1); mem_req_out stays 1.
      - If cnt==3 (same edge):
        - Write linebuf[0..2] plus mem_data_in into data[idx].
        - Set tag[idx] and valid[idx]=1.
        - mem_req_out <= 0.
        - Go to IDLE.
    - Without mem_done_in: hold all registers.
- Latency:
  - Miss seen in cycle 0 → mem_req_out high from cycle 1.
  - With done returned n cycles after each request, the line is valid and hit asserts the cycle after the 4th done.
  - Minimum miss penalty is 5 cycles.
- Handshake:
  - mem_addr_out is stable while mem_req_out is high until the matching mem_done_in.
  - mem_done_in while mem_req_out=0 is ignored.
  - Exactly 4 requests per refill, in ascending word order.
- Address change during REFILL (rollback, fetch redirect): the refill always completes into the latched index/tag. After that, the new address is looked up normally and may miss again.
- The refilled index is overwritten unconditionally: valid is cleared for nothing else, and the old tag is replaced.
- rdy_in=0:
  - state, cnt, mem_req_out, mem_addr_out, array, linebuf all hold.
  - The hit path stays combinational.
  - The memory controller is paused by the same rdy_in and does not pulse mem_done_in.
- Reset (async, rst_in=0), any time including mid-refill:
  - All valid bits = 0, state=IDLE, cnt=0, mem_req_out=0, mem_addr_out=0.
  - The partial linebuf is discarded; tag/data contents don't care.
  - if_instr_en_out=0, if_instr_out=0.
- Wrap: miss_base + 12 never crosses a line, so there is no carry beyond bit 3.

Test Plan:
- Reset, if_addr_in=0x0, memory words 0x00000013,0x00100093,0x00200113,0x00300193 at 0x0..0xC, done 2 cycles after each request → mem_addr_out sequence 0x0,0x4,0x8,0xC; if_instr_en_out=0 throughout; the cycle after the 4th done, if_instr_en_out=1, if_instr_out=0x00000013; then addr 0x8 → 0x00200113 same cycle, no request.
- Conflict: after line at 0x0 is filled, if_addr_in=0x400 (same index, tag differs) → miss, refill from 0x400..0x40C; then 0x0 misses again.
- Redirect mid-refill: miss at 0x20, after 2nd done change if_addr_in to 0x100 → remaining requests 0x28,0x2C; then new miss refill 0x100..0x10C; 0x24 hits afterwards with correct data.
- rdy_in low for 5 cycles between 1st and 2nd done → mem_addr_out held at 0x4, cnt unchanged, refill completes normally after rdy_in returns.
- Async reset asserted between 3rd and 4th done → mem_req_out=0 immediately without a clock edge; after release, address 0x0 misses, i.e. the partial line was not made valid.
- Spurious mem_done_in while IDLE with data 0xDEADBEEF → no array change; subsequent hits return the original data.
